rr_mux: RTL and testbench
=========================

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width per channel in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning number of input channels (2..16).
REQ-003 The block SHALL define SEL_W = max(1, ceil(log2(CHANNELS))) for all channel-index signals.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration.
REQ-007 sel  input  SEL_W  channel index used when mode = 0.
REQ-008 in_data  input  CHANNELS*WIDTH  packed inputs; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 in_valid  input  CHANNELS  per-channel data-valid.
REQ-010 in_ready  output  CHANNELS  per-channel accept; at most one bit high.
REQ-011 out_data  output  WIDTH  registered selected data.
REQ-012 out_chan  output  SEL_W  registered index of the channel that supplied out_data.
REQ-013 out_valid  output  1  out_data/out_chan hold an untaken word.
REQ-014 out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Function
REQ-015 The block SHALL hold one output word; load_en = !out_valid || out_ready (combinational).
REQ-016 Mode 0: grant SHALL be channel sel when sel < CHANNELS and in_valid[sel] = 1; otherwise no grant.
REQ-017 Mode 1: grant SHALL be the first k with in_valid[k] = 1, searching ptr, ptr+1, ... modulo CHANNELS; no grant if in_valid = 0.
REQ-018 in_ready[g] SHALL be 1 only for granted channel g and only when load_en = 1 and rst_n = 1; all other bits 0.
REQ-019 A transfer occurs when in_valid[g] && in_ready[g]; in_ready SHALL never depend on in_ready of other channels.
REQ-020 On transfer, next cycle: out_data = in_data[g], out_chan = g, out_valid = 1 (latency 1 cycle).
REQ-021 When out_valid && out_ready and no transfer occurs, out_valid SHALL clear next cycle; out_data/out_chan hold.
REQ-022 Simultaneous downstream take and upstream transfer SHALL replace the word with no bubble (full throughput, 1 word/cycle).
REQ-023 When out_valid && !out_ready, out_data, out_chan, out_valid SHALL remain stable and in_ready SHALL be all 0.
REQ-024 ptr (SEL_W bits, internal) SHALL update on every transfer, in either mode, to (g+1) mod CHANNELS; g = CHANNELS-1 wraps ptr to 0.
REQ-025 ptr SHALL not change on cycles without transfer.
REQ-026 mode and sel changes SHALL take effect on the same cycle's grant; the held output word SHALL be unaffected.
REQ-027 With CHANNELS not a power of two, ptr values >= CHANNELS SHALL never occur.

Reset
REQ-028 While rst_n = 0 at a clk edge: out_valid = 0, out_data = 0, out_chan = 0, ptr = 0.
REQ-029 in_ready SHALL be all 0 while rst_n = 0, regardless of other inputs.
REQ-030 Reset asserted mid-operation SHALL discard the held word; no transfer is counted on that edge.
REQ-031 First cycle after reset release SHALL accept a transfer if a grant exists.

Verification
REQ-032 Reset: rst_n = 0 two cycles, in_valid = 4'hF -> out_valid = 0, out_data = 0, in_ready = 0; release -> round-robin grants ch0 first.
REQ-033 Fixed mode: mode = 0, in_data = {8'h44,8'h33,8'h22,8'h11}, in_valid = 4'hF, out_ready = 1, sel stepping 0,1,2,3 -> out_data 11,22,33,44 each one cycle after sel, out_chan 0..3.
REQ-034 Round-robin fairness: mode = 1, in_valid = 4'hF held, out_ready = 1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3 (wrap-around).
REQ-035 Skip idle: mode = 1, in_valid = 4'b1010 -> out_chan alternates 1,3,1,3; ptr after ch3 = 0.
REQ-036 Backpressure: out_ready = 0 with out_valid = 1 for 3 cycles -> out_data stable, in_ready = 0; out_ready = 1 -> take and new load in same cycle, no bubble.
REQ-037 Invalid sel: mode = 0, CHANNELS = 3, sel = 3 -> in_ready = 0, out_valid falls after existing word taken.

Source files
------------

// File: rtl/rr_mux_if.sv
// rr_mux_if -- handshake bundle between an rr_mux and its neighbours.
//
// Handshake rules (both sides): a word moves on a clock edge exactly when
// valid and ready are both high on that edge.  A producer holding valid high
// keeps its data stable until the word moves.  Ready may depend on valid
// but never on the ready of another channel.
//
// Signals:
//   mode      0 = fixed select via sel, 1 = round-robin arbitration
//   sel       channel index used in fixed mode
//   in_data   packed channel words, channel k at [k*WIDTH +: WIDTH]
//   in_valid  per-channel valid
//   in_ready  per-channel accept (one-hot or zero)
//   out_data  registered selected word
//   out_chan  channel that supplied out_data
//   out_valid out_data/out_chan hold an untaken word
//   out_ready downstream accept
//
// master: the side driving the inputs and consuming the outputs.
// slave : the rr_mux itself.
interface rr_mux_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/rr_mux.sv
// rr_mux -- N-channel multiplexer with a one-word output register.
// Channel choice is either a fixed index (mode 0) or round-robin starting at
// an internal pointer (mode 1).  The output register reloads on the same
// cycle it is taken, so throughput is one word per cycle.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   bus       rr_mux_if slave modport (handshake and data)
//   dbg_ptr_o current round-robin pointer, for observation only
module rr_mux #(
    parameter  int WIDTH    = 8,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rr_mux_if.slave          bus,
    output logic [SEL_W-1:0] dbg_ptr_o
);

    logic [SEL_W-1:0]    ptr_q, ptr_d;
    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic [SEL_W-1:0]    out_chan_q, out_chan_d;
    logic                out_valid_q, out_valid_d;

    logic                grant_vld;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;
    logic                load_en;
    logic                xfer;
    logic [CHANNELS-1:0] in_ready;
    int                  rr_sum;
    logic [SEL_W-1:0]    rr_idx;

    // Grant selection.  The round-robin scan runs from the farthest offset
    // back toward ptr so the closest requester after ptr is left as winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_sum    = 0;
        rr_idx    = '0;
        if (!bus.mode) begin
            // Only indices below CHANNELS are compared, so an out-of-range
            // sel simply finds no grant.
            for (int k = 0; k < CHANNELS; k++) begin
                if (bus.sel == SEL_W'(k) && bus.in_valid[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(k);
                end
            end
        end else begin
            for (int i = CHANNELS - 1; i >= 0; i--) begin
                rr_sum = int'(ptr_q) + i;
                if (rr_sum >= CHANNELS) begin
                    rr_sum = rr_sum - CHANNELS;
                end
                rr_idx = SEL_W'(rr_sum);
                for (int k = 0; k < CHANNELS; k++) begin
                    if (rr_idx == SEL_W'(k) && bus.in_valid[k]) begin
                        grant_vld = 1'b1;
                        grant_idx = rr_idx;
                    end
                end
            end
        end
    end

    // Data of the granted channel.
    always_comb begin
        grant_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (grant_idx == SEL_W'(k)) begin
                grant_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // The register can take a new word when empty or being emptied now.
    assign load_en = !out_valid_q || bus.out_ready;

    always_comb begin
        for (int k = 0; k < CHANNELS; k++) begin
            in_ready[k] = rst_n && load_en && grant_vld && (grant_idx == SEL_W'(k));
        end
    end

    assign xfer = |(in_ready & bus.in_valid);

    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            // Explicit wrap keeps ptr inside 0..CHANNELS-1 for any CHANNELS.
            ptr_d       = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_data  = out_data_q;
    assign bus.out_chan  = out_chan_q;
    assign bus.out_valid = out_valid_q;
    assign dbg_ptr_o     = ptr_q;

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux -- drives a 4-channel and a 3-channel rr_mux with shared stimulus
// and checks both against a transaction-level model every cycle, plus
// directed expectations for the named scenarios.
module tb_rr_mux;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- stimulus ----------------
    logic        mode;
    logic [1:0]  sel;
    logic [31:0] in_data;
    logic [3:0]  in_valid;
    logic        out_ready;
    logic [1:0]  ptr4, ptr3;

    rr_mux_if #(.WIDTH(8), .CHANNELS(4)) if4 ();
    rr_mux_if #(.WIDTH(8), .CHANNELS(3)) if3 ();

    assign if4.mode      = mode;
    assign if4.sel       = sel;
    assign if4.in_data   = in_data;
    assign if4.in_valid  = in_valid;
    assign if4.out_ready = out_ready;
    assign if3.mode      = mode;
    assign if3.sel       = sel;
    assign if3.in_data   = in_data[23:0];
    assign if3.in_valid  = in_valid[2:0];
    assign if3.out_ready = out_ready;

    rr_mux #(.WIDTH(8), .CHANNELS(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave), .dbg_ptr_o(ptr4));
    rr_mux #(.WIDTH(8), .CHANNELS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave), .dbg_ptr_o(ptr3));

    // ---------------- scoreboard ----------------
    int cmp_cnt = 0;
    int err_cnt = 0;

    // Model state per unit (0 = 4 channels, 1 = 3 channels).
    bit         m_valid[2], n_valid[2];
    logic [7:0] m_data[2],  n_data[2];
    int         m_chan[2],  n_chan[2];
    int         m_ptr[2],   n_ptr[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Which channel should win, or -1 for none.
    function automatic int exp_grant(input int n, input int ptr);
        if (mode == 1'b0) begin
            if (int'(sel) < n && in_valid[sel]) return int'(sel);
            return -1;
        end
        for (int i = 0; i < n; i++) begin
            if (in_valid[(ptr + i) % n]) return (ptr + i) % n;
        end
        return -1;
    endfunction

    task automatic check_unit(input int u, input int n, input logic [3:0] o_ready,
                              input logic o_valid, input logic [7:0] o_data,
                              input logic [1:0] o_chan, input logic [1:0] o_ptr);
        int         g;
        logic [3:0] e_ready;
        string      p;
        p = (u == 0) ? "u4" : "u3";
        g = exp_grant(n, m_ptr[u]);
        e_ready = (rst_n && (!m_valid[u] || out_ready) && g >= 0) ? 4'(1 << g) : 4'h0;
        check({p, ".in_ready"},  32'(o_ready), 32'(e_ready));
        check({p, ".out_valid"}, 32'(o_valid), 32'(m_valid[u]));
        check({p, ".out_data"},  32'(o_data),  32'(m_data[u]));
        check({p, ".out_chan"},  32'(o_chan),  32'(m_chan[u]));
        check({p, ".ptr"},       32'(o_ptr),   32'(m_ptr[u]));
        n_valid[u] = m_valid[u];
        n_data[u]  = m_data[u];
        n_chan[u]  = m_chan[u];
        n_ptr[u]   = m_ptr[u];
        if (!rst_n) begin
            n_valid[u] = 1'b0;
            n_data[u]  = 8'h00;
            n_chan[u]  = 0;
            n_ptr[u]   = 0;
        end else if (e_ready != 4'h0) begin
            n_valid[u] = 1'b1;
            n_data[u]  = in_data[g*8 +: 8];
            n_chan[u]  = g;
            n_ptr[u]   = (g + 1) % n;
        end else if (out_ready) begin
            n_valid[u] = 1'b0;
        end
    endtask

    // One clock: check mid-cycle, advance model on the edge, settle #1 after.
    task automatic cycle();
        @(negedge clk);
        check_unit(0, 4, if4.in_ready, if4.out_valid, if4.out_data, if4.out_chan, ptr4);
        check_unit(1, 3, {1'b0, if3.in_ready}, if3.out_valid, if3.out_data, if3.out_chan, ptr3);
        @(posedge clk);
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = n_valid[u];
            m_data[u]  = n_data[u];
            m_chan[u]  = n_chan[u];
            m_ptr[u]   = n_ptr[u];
        end
        #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random sequence ----------------
    logic [7:0] held;

    initial begin
        rst_n = 1'b0; mode = 1'b1; sel = 2'd0;
        in_data = 32'h44332211; in_valid = 4'hF; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int u = 0; u < 2; u++) begin
            m_valid[u] = 1'b0; m_data[u] = 8'h00; m_chan[u] = 0; m_ptr[u] = 0;
        end

        // Reset held two cycles with all channels requesting.
        cycle();
        check("rst.out_valid", 32'(if4.out_valid), 32'd0);
        check("rst.out_data",  32'(if4.out_data),  32'd0);
        check("rst.in_ready",  32'(if4.in_ready),  32'd0);

        // Release: round-robin starts at channel 0 and wraps.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("rr.out_chan",  32'(if4.out_chan),  32'(i % 4));
            check("rr.out_valid", 32'(if4.out_valid), 32'd1);
        end

        // Fixed select stepping through channels.
        mode = 1'b0;
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            cycle();
            check("fix.out_data", 32'(if4.out_data), 32'(8'h11 * (s + 1)));
            check("fix.out_chan", 32'(if4.out_chan), 32'(s));
        end

        // Skip idle channels.
        mode = 1'b1; in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("skip.out_chan", 32'(if4.out_chan), (i % 2 == 0) ? 32'd1 : 32'd3);
        end
        check("skip.ptr", 32'(ptr4), 32'd0);

        // Backpressure for three cycles, then take and reload together.
        in_valid = 4'hF; out_ready = 1'b0;
        held = if4.out_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp.out_data",  32'(if4.out_data),  32'(held));
            check("bp.out_valid", 32'(if4.out_valid), 32'd1);
            check("bp.in_ready",  32'(if4.in_ready),  32'd0);
        end
        out_ready = 1'b1;
        cycle();
        check("bp.reload_valid", 32'(if4.out_valid), 32'd1);
        check("bp.reload_chan",  32'(if4.out_chan),  32'd0);
        check("bp.reload_data",  32'(if4.out_data),  32'h11);

        // Out-of-range sel on the 3-channel unit.
        mode = 1'b0; sel = 2'd2;
        cycle();
        check("inv.load_chan", 32'(if3.out_chan), 32'd2);
        sel = 2'd3; out_ready = 1'b0;
        cycle();
        check("inv.hold_ready", 32'(if3.in_ready), 32'd0);
        out_ready = 1'b1;
        check("inv.ready", 32'(if3.in_ready), 32'd0);
        cycle();
        check("inv.out_valid", 32'(if3.out_valid), 32'd0);

        // Reset in the middle of a held word.
        mode = 1'b1; out_ready = 1'b0; rst_n = 1'b0;
        cycle();
        check("midrst.out_valid", 32'(if4.out_valid), 32'd0);
        check("midrst.ptr",       32'(ptr4),          32'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        cycle();
        check("midrst.first_chan", 32'(if4.out_chan), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            rst_n     = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
